// File: rtl/shift_sequencer.sv
// Multi-pass controller for a shared 10-bit barrel shifter: splits a shift request
// into single-cycle passes and feeds each pass result back as the next input.
module shift_sequencer #(
  parameter int AMT_W     = 4,
  parameter int MAX_LSTEP = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_data,
  input  logic             in_dir,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_data,
  output logic [9:0]       sh_data,
  output logic [2:0]       sh_amt,
  input  logic [9:0]       sh_result
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [AMT_W-1:0] LSTEP = AMT_W'(MAX_LSTEP);
  localparam logic [2:0]       CODE_RIGHT1 = 3'd7;

  state_t           state;
  logic [9:0]       acc;
  logic [AMT_W-1:0] rem;
  logic             dir;
  logic [AMT_W-1:0] step;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    step   = '0;
    sh_amt = 3'd0;
    if (dir) begin
      step = AMT_W'(1);
    end else begin
      step = (rem < LSTEP) ? rem : LSTEP;
    end
    if (state == RUN) begin
      sh_amt = dir ? CODE_RIGHT1 : 3'(step);
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign sh_data   = acc;

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so out_data/sh_data read
      // zero after reset rather than stale contents.
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= in_data;
            rem   <= in_amt;
            dir   <= in_dir;
            state <= (in_amt == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Shifts of 10+ still run every pass; the word simply drains to zero.
          acc <= sh_result;
          rem <= rem - step;
          if (rem == step) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; models the external barrel
// shifter combinationally and checks every cycle of each scenario.
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic       in_dir;
  logic [3:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [9:0] sh_data;
  logic [2:0] sh_amt;
  logic [9:0] sh_result;

  int checks   = 0;
  int failures = 0;

  shift_sequencer #(.AMT_W(4), .MAX_LSTEP(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sh_data   (sh_data),
    .sh_amt    (sh_amt),
    .sh_result (sh_result)
  );

  // External shifter: codes 0..6 shift left, code 7 shifts right by one.
  always_comb begin
    if (sh_amt == 3'd7) sh_result = sh_data >> 1;
    else                sh_result = 10'(sh_data << sh_amt);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_in_ready", 16'(in_ready), 16'h1);
    check("hs_out_valid", 16'(out_valid), 16'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_amt = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 16'(in_ready), 16'h0);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_data", 16'(out_data), 16'h0);
    check("rst_sh_amt", 16'(sh_amt), 16'h0);
    check("rst_sh_data", 16'(sh_data), 16'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 16'(in_ready), 16'h1);

    // Left 9 on 0x001: passes of 6 then 3.
    in_valid = 1'b1; in_data = 10'h001; in_dir = 1'b0; in_amt = 4'd9;
    tick();
    in_valid = 1'b0; in_data = 10'h3FF; in_dir = 1'b1; in_amt = 4'd15;
    check("l9_p1_amt", 16'(sh_amt), 16'h6);
    check("l9_p1_data", 16'(sh_data), 16'h001);
    check("l9_p1_in_ready", 16'(in_ready), 16'h0);
    check("l9_p1_out_valid", 16'(out_valid), 16'h0);
    tick();
    check("l9_p2_amt", 16'(sh_amt), 16'h3);
    check("l9_p2_data", 16'(sh_data), 16'h040);
    tick();
    check("l9_valid", 16'(out_valid), 16'h1);
    check("l9_data", 16'(out_data), 16'h200);
    check("l9_done_sh_amt", 16'(sh_amt), 16'h0);
    handshake();

    // Right 4 on 0x3FF: four serial passes; in_dir change after accept is ignored.
    in_valid = 1'b1; in_data = 10'h3FF; in_dir = 1'b1; in_amt = 4'd4;
    tick();
    in_valid = 1'b0; in_dir = 1'b0;
    check("r4_p1_amt", 16'(sh_amt), 16'h7);
    check("r4_p1_data", 16'(sh_data), 16'h3FF);
    tick();
    check("r4_p2_amt", 16'(sh_amt), 16'h7);
    check("r4_p2_data", 16'(sh_data), 16'h1FF);
    tick();
    check("r4_p3_amt", 16'(sh_amt), 16'h7);
    check("r4_p3_data", 16'(sh_data), 16'h0FF);
    tick();
    check("r4_p4_amt", 16'(sh_amt), 16'h7);
    check("r4_p4_data", 16'(sh_data), 16'h07F);
    check("r4_p4_out_valid", 16'(out_valid), 16'h0);
    tick();
    check("r4_valid", 16'(out_valid), 16'h1);
    check("r4_data", 16'(out_data), 16'h03F);
    handshake();

    // Zero amount goes straight to DONE.
    in_valid = 1'b1; in_data = 10'h2A5; in_dir = 1'b0; in_amt = 4'd0;
    tick();
    in_valid = 1'b0;
    check("z_valid", 16'(out_valid), 16'h1);
    check("z_data", 16'(out_data), 16'h2A5);
    check("z_sh_amt", 16'(sh_amt), 16'h0);
    handshake();

    // Left 15 on 0x3FF: passes 6, 6, 3, result drained to zero.
    in_valid = 1'b1; in_data = 10'h3FF; in_dir = 1'b0; in_amt = 4'd15;
    tick();
    check("l15_p1_amt", 16'(sh_amt), 16'h6);
    check("l15_p1_data", 16'(sh_data), 16'h3FF);
    // Second request held on in_valid from here through the backpressure window.
    in_data = 10'h155; in_dir = 1'b0; in_amt = 4'd1;
    tick();
    check("l15_p2_amt", 16'(sh_amt), 16'h6);
    check("l15_p2_data", 16'(sh_data), 16'h3C0);
    tick();
    check("l15_p3_amt", 16'(sh_amt), 16'h3);
    check("l15_p3_data", 16'(sh_data), 16'h000);
    tick();
    check("l15_valid", 16'(out_valid), 16'h1);
    check("l15_data", 16'(out_data), 16'h000);

    // Backpressure: five cycles with out_ready low.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("bp_out_valid", 16'(out_valid), 16'h1);
      check("bp_out_data", 16'(out_data), 16'h000);
      check("bp_in_ready", 16'(in_ready), 16'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 16'(in_ready), 16'h0);
    tick();
    out_ready = 1'b0;
    check("bp_idle_in_ready", 16'(in_ready), 16'h1);
    check("bp_idle_out_valid", 16'(out_valid), 16'h0);
    tick();
    in_valid = 1'b0;
    check("q2_p1_amt", 16'(sh_amt), 16'h1);
    check("q2_p1_data", 16'(sh_data), 16'h155);
    check("q2_in_ready", 16'(in_ready), 16'h0);
    tick();
    check("q2_valid", 16'(out_valid), 16'h1);
    check("q2_data", 16'(out_data), 16'h2AA);
    handshake();

    // Reset during a long right shift aborts it.
    in_valid = 1'b1; in_data = 10'h3FF; in_dir = 1'b1; in_amt = 4'd12;
    tick();
    in_valid = 1'b0;
    check("ab_p1_amt", 16'(sh_amt), 16'h7);
    tick();
    tick();
    check("ab_p3_data", 16'(sh_data), 16'h0FF);
    rst = 1'b1;
    #1;
    check("ab_rst_in_ready", 16'(in_ready), 16'h0);
    tick();
    rst = 1'b0;
    check("ab_out_valid", 16'(out_valid), 16'h0);
    check("ab_out_data", 16'(out_data), 16'h000);
    check("ab_sh_amt", 16'(sh_amt), 16'h0);
    check("ab_sh_data", 16'(sh_data), 16'h000);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("ab_no_valid", 16'(out_valid), 16'h0);
      check("ab_idle_ready", 16'(in_ready), 16'h1);
    end

    in_valid = 1'b1; in_data = 10'h001; in_dir = 1'b0; in_amt = 4'd1;
    tick();
    in_valid = 1'b0;
    check("after_p1_amt", 16'(sh_amt), 16'h1);
    tick();
    check("after_valid", 16'(out_valid), 16'h1);
    check("after_data", 16'(out_data), 16'h002);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
